pdsch_sym_sched: RTL and testbench

Symbol-level scheduler for the PDSCH dimension-reduction path. It collects the per-lane end-of-symbol pulses from the eight CPRI rx unpack lanes and issues the `sym1_done` ping-pong swap that releases a completed symbol to `pdsch_dr_core`. It then holds off the next swap until the core reports end of packet, and tracks symbol and slot indices. It sits between the unpack lanes and the core in `pdsch_dr_top`, replacing the undriven `sym1_done` register.

---
 rtl/pdsch_sym_sched.sv | 139 +++++++++++++
 tb/tb_pdsch_sym_sched.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pdsch_sym_sched.sv
// rtl/pdsch_sym_sched.sv - PDSCH symbol swap scheduler across the CPRI unpack lanes
// Lane-skew timeout is built only when PDSCH_SCHED_TMO_EN is defined.
module pdsch_sym_sched #(
  parameter int LANE    = 8,
  parameter int SYM_NUM = 14,
  parameter int SLOT_W  = 8,
  parameter int TMO_CYC = 4096
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [LANE-1:0]   i_iq_last,
  input  logic              i_core_eop,
  output logic              o_sym_done,
  output logic              o_buf_sel,
  output logic [3:0]        o_sym_idx,
  output logic [SLOT_W-1:0] o_slot_idx,
  output logic              o_busy,
  output logic              o_lane_err,
  output logic [LANE-1:0]   o_miss_mask,
  output logic              o_ovf
);

  typedef enum logic [1:0] {COLLECT, SWAP, RUN} state_t;

  localparam logic [3:0]  SYM_LAST = 4'(SYM_NUM - 1);
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);

  state_t            state_q;
  logic [LANE-1:0]   mask_q;
  logic [LANE-1:0]   mask_d;
  logic [3:0]        sym_cnt_q;
  logic [SLOT_W-1:0] slot_cnt_q;
  logic              sym_done_q;
  logic              buf_sel_q;
  logic [3:0]        sym_idx_q;
  logic [SLOT_W-1:0] slot_idx_q;
  logic              busy_q;
  logic              ovf_q;
  logic              all_done;
  logic              swap_go;

  // Pulses landing in the same cycle count toward completion immediately.
  assign mask_d   = mask_q | i_iq_last;
  assign all_done = &mask_d;

`ifdef PDSCH_SCHED_TMO_EN
  logic [15:0]     tmo_q;
  logic            tmo_hit;
  logic            lane_err_q;
  logic [LANE-1:0] miss_q;

  assign tmo_hit = (tmo_q == TMO_LAST) && (|mask_d);
  assign swap_go = all_done | tmo_hit;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tmo_q      <= '0;
      lane_err_q <= 1'b0;
      miss_q     <= '0;
    end else begin
      lane_err_q <= 1'b0;
      if (state_q == COLLECT) begin
        if (swap_go) begin
          tmo_q      <= '0;
          lane_err_q <= ~all_done;
          miss_q     <= all_done ? '0 : ~mask_d;
        end else if (|mask_d) begin
          tmo_q <= tmo_q + 16'd1;
        end
      end
    end
  end

  assign o_lane_err  = lane_err_q;
  assign o_miss_mask = miss_q;
`else
  logic unused_tmo;
  assign unused_tmo  = ^TMO_LAST;
  assign swap_go     = all_done;
  assign o_lane_err  = 1'b0;
  assign o_miss_mask = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= COLLECT;
      mask_q     <= '0;
      sym_cnt_q  <= '0;
      slot_cnt_q <= '0;
      sym_done_q <= 1'b0;
      buf_sel_q  <= 1'b0;
      sym_idx_q  <= '0;
      slot_idx_q <= '0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      sym_done_q <= 1'b0;
      ovf_q      <= |(i_iq_last & mask_q);
      mask_q     <= mask_d;
      case (state_q)
        COLLECT: begin
          if (swap_go) begin
            state_q    <= SWAP;
            sym_done_q <= 1'b1;
            buf_sel_q  <= ~buf_sel_q;
            sym_idx_q  <= sym_cnt_q;
            slot_idx_q <= slot_cnt_q;
            mask_q     <= '0;
            if (sym_cnt_q == SYM_LAST) begin
              sym_cnt_q  <= '0;
              slot_cnt_q <= slot_cnt_q + SLOT_W'(1);
            end else begin
              sym_cnt_q <= sym_cnt_q + 4'd1;
            end
          end
        end
        SWAP: begin
          state_q <= RUN;
          busy_q  <= 1'b1;
        end
        RUN: begin
          if (i_core_eop) begin
            state_q <= COLLECT;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign o_sym_done = sym_done_q;
  assign o_buf_sel  = buf_sel_q;
  assign o_sym_idx  = sym_idx_q;
  assign o_slot_idx = slot_idx_q;
  assign o_busy     = busy_q;
  assign o_ovf      = ovf_q;

endmodule

// File: tb/tb_pdsch_sym_sched.sv
// tb/tb_pdsch_sym_sched.sv - directed self-checking bench for pdsch_sym_sched
// Timeout checks are compiled in only when PDSCH_SCHED_TMO_EN is defined.
module tb_pdsch_sym_sched;

`ifdef PDSCH_SCHED_TMO_EN
  localparam int TB_TMO = 64;
`else
  localparam int TB_TMO = 4096;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] iq_last;
  logic       core_eop;
  logic       sym_done;
  logic       buf_sel;
  logic [3:0] sym_idx;
  logic [7:0] slot_idx;
  logic       busy;
  logic       lane_err;
  logic [7:0] miss_mask;
  logic       ovf;

  int   errors = 0;
  int   checks = 0;
  int   exp_sym = 0;
  int   exp_slot = 0;
  logic exp_buf = 1'b0;

  pdsch_sym_sched #(
    .LANE(8), .SYM_NUM(14), .SLOT_W(8), .TMO_CYC(TB_TMO)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_iq_last(iq_last),
    .i_core_eop(core_eop),
    .o_sym_done(sym_done),
    .o_buf_sel(buf_sel),
    .o_sym_idx(sym_idx),
    .o_slot_idx(slot_idx),
    .o_busy(busy),
    .o_lane_err(lane_err),
    .o_miss_mask(miss_mask),
    .o_ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".done"},  32'(sym_done),  0);
    check({tag, ".buf"},   32'(buf_sel),   0);
    check({tag, ".sym"},   32'(sym_idx),   0);
    check({tag, ".slot"},  32'(slot_idx),  0);
    check({tag, ".busy"},  32'(busy),      0);
    check({tag, ".err"},   32'(lane_err),  0);
    check({tag, ".miss"},  32'(miss_mask), 0);
    check({tag, ".ovf"},   32'(ovf),       0);
  endtask

  // Expected released symbol/slot advance 0..13 then wrap with a slot bump.
  task automatic check_swap(input string tag);
    exp_buf = ~exp_buf;
    check({tag, ".done"}, 32'(sym_done), 1);
    check({tag, ".buf"},  32'(buf_sel),  32'(exp_buf));
    check({tag, ".sym"},  32'(sym_idx),  32'(exp_sym));
    check({tag, ".slot"}, 32'(slot_idx), 32'(exp_slot));
    check({tag, ".busy0"}, 32'(busy),    0);
    if (exp_sym == 13) begin
      exp_sym  = 0;
      exp_slot = (exp_slot + 1) % 256;
    end else begin
      exp_sym++;
    end
  endtask

  task automatic full_round(input string tag);
    iq_last = 8'hFF;
    step();
    iq_last = 8'h00;
    check_swap(tag);
    step();
    check({tag, ".busy"}, 32'(busy), 1);
    check({tag, ".done_lo"}, 32'(sym_done), 0);
    core_eop = 1'b1;
    step();
    core_eop = 1'b0;
    check({tag, ".busy_off"}, 32'(busy), 0);
    step();
    check({tag, ".no_swap"}, 32'(sym_done), 0);
  endtask

  initial begin
    reset    = 1'b1;
    iq_last  = 8'h00;
    core_eop = 1'b0;
    step();
    step();
    reset = 1'b0;
    check_reset("rst");
    step();
    check("rst.idle_done", 32'(sym_done), 0);

    full_round("all_lanes");

    for (int k = 0; k < 8; k++) begin
      iq_last = 8'(1 << k);
      step();
      iq_last = 8'h00;
      if (k < 7) check("stagger.wait", 32'(sym_done), 0);
      else       check_swap("stagger");
    end
    repeat (10) step();
    check("stagger.busy", 32'(busy), 1);
    check("stagger.single", 32'(sym_done), 0);
    core_eop = 1'b1;
    step();
    core_eop = 1'b0;
    check("stagger.busy_off", 32'(busy), 0);
    step();

    for (int i = 0; i < 12; i++) full_round("wrap");
    full_round("wrap15");

    core_eop = 1'b1;
    iq_last  = 8'h0F;
    step();
    core_eop = 1'b0;
    iq_last  = 8'h00;
    check("eop_ignored.busy", 32'(busy), 0);
    check("eop_ignored.done", 32'(sym_done), 0);
    step();
    iq_last = 8'hF0;
    step();
    iq_last = 8'h00;
    check_swap("split");
    step();
    iq_last = 8'hFF;
    step();
    iq_last = 8'h08;
    check("ovf.none", 32'(ovf), 0);
    step();
    iq_last = 8'h00;
    check("ovf.lane3", 32'(ovf), 1);
    step();
    check("ovf.pulse", 32'(ovf), 0);
    repeat (5) step();
    check("hold.done", 32'(sym_done), 0);
    check("hold.busy", 32'(busy), 1);
    core_eop = 1'b1;
    step();
    core_eop = 1'b0;
    check("back2back.busy_off", 32'(busy), 0);
    check("back2back.wait", 32'(sym_done), 0);
    step();
    check_swap("back2back");
    step();
    check("back2back.busy", 32'(busy), 1);
    core_eop = 1'b1;
    step();
    core_eop = 1'b0;
    step();

    iq_last = 8'h7F;
    step();
    iq_last = 8'h00;
`ifdef PDSCH_SCHED_TMO_EN
    repeat (62) begin
      check("tmo.wait", 32'(sym_done), 0);
      step();
    end
    check("tmo.wait_last", 32'(sym_done), 0);
    step();
    check_swap("tmo");
    check("tmo.err", 32'(lane_err), 1);
    check("tmo.miss", 32'(miss_mask), 32'h80);
    step();
    check("tmo.err_pulse", 32'(lane_err), 0);
    check("tmo.miss_hold", 32'(miss_mask), 32'h80);
`else
    repeat (100) begin
      check("notmo.wait", 32'(sym_done), 0);
      step();
    end
    check("notmo.err", 32'(lane_err), 0);
    iq_last = 8'h80;
    step();
    iq_last = 8'h00;
    check_swap("notmo");
    check("notmo.miss", 32'(miss_mask), 0);
    step();
`endif
    core_eop = 1'b1;
    step();
    core_eop = 1'b0;
    step();

    iq_last = 8'hFF;
    step();
    iq_last = 8'h00;
    check_swap("pre_rst");
    step();
    iq_last = 8'h0F;
    step();
    iq_last = 8'h00;
    reset   = 1'b1;
    step();
    reset = 1'b0;
    check_reset("mid_rst");
    exp_sym  = 0;
    exp_slot = 0;
    exp_buf  = 1'b0;
    iq_last = 8'hF0;
    step();
    iq_last = 8'h00;
    check("mid_rst.discard", 32'(sym_done), 0);
    step();
    check("mid_rst.no_swap", 32'(sym_done), 0);
    full_round("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
